// File: rtl/dout_display.sv
// Output-side display driver: captures the CPU data word, converts it to
// sign plus three BCD digits with a sequential double-dabble engine, and
// scans a 4-digit active-low seven-segment display with leading-zero blanking.
module dout_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int SIGNED      = 1
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic [7:0] Dout,
   input  logic       Dval,
   output logic [6:0] Seg,
   output logic [3:0] Anode,
   output logic       Busy
);

   localparam int             CW          = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]  CNT_MAX     = CW'(REFRESH_DIV - 1);
   localparam logic           SIGNED_MODE = (SIGNED != 0);
   localparam logic [6:0]     SEG_BLANK   = 7'h7F;
   localparam logic [6:0]     SEG_MINUS   = 7'h3F;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   state_t      state, state_next;
   logic [7:0]  cap, cap_next;
   logic [7:0]  mag, mag_next;
   logic [11:0] bcd, bcd_next, bcd_adj;
   logic [2:0]  shift_cnt, shift_cnt_next;
   logic        neg, neg_next;
   logic        show_load;
   logic [19:0] shifted;

   logic [3:0]  hund, tens, units;
   logic        shown_neg;

   logic [CW-1:0] refresh_cnt;
   logic [1:0]    digit_idx;
   logic [6:0]    seg_next;
   logic [3:0]    anode_next;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      case (d)
         4'd0:    seg_encode = 7'h40;
         4'd1:    seg_encode = 7'h79;
         4'd2:    seg_encode = 7'h24;
         4'd3:    seg_encode = 7'h30;
         4'd4:    seg_encode = 7'h19;
         4'd5:    seg_encode = 7'h12;
         4'd6:    seg_encode = 7'h02;
         4'd7:    seg_encode = 7'h78;
         4'd8:    seg_encode = 7'h00;
         4'd9:    seg_encode = 7'h10;
         default: seg_encode = SEG_BLANK;
      endcase
   endfunction

   assign Busy = (state != IDLE);

   // Add-3 correction of every BCD nibble that has reached 5, ahead of the shift
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) begin
            bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
         end
      end
      shifted = {bcd_adj, mag} << 1;
   end

   // Conversion FSM next-state and datapath next values
   always_comb begin
      state_next     = state;
      cap_next       = cap;
      mag_next       = mag;
      bcd_next       = bcd;
      shift_cnt_next = shift_cnt;
      neg_next       = neg;
      show_load      = 1'b0;
      case (state)
         IDLE: begin
            if (Dval && (Dout != cap)) begin
               cap_next   = Dout;
               state_next = LOAD;
            end
         end
         LOAD: begin
            neg_next       = SIGNED_MODE & cap[7];
            mag_next       = (SIGNED_MODE & cap[7]) ? (~cap + 8'd1) : cap;
            bcd_next       = '0;
            shift_cnt_next = '0;
            state_next     = SHIFT;
         end
         SHIFT: begin
            bcd_next       = shifted[19:8];
            mag_next       = shifted[7:0];
            shift_cnt_next = shift_cnt + 3'd1;
            if (shift_cnt == 3'd7) begin
               state_next = DONE;
            end
         end
         DONE: begin
            show_load  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Conversion FSM state and scratch registers
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= IDLE;
         cap       <= '0;
         mag       <= '0;
         bcd       <= '0;
         shift_cnt <= '0;
         neg       <= 1'b0;
      end else begin
         state     <= state_next;
         cap       <= cap_next;
         mag       <= mag_next;
         bcd       <= bcd_next;
         shift_cnt <= shift_cnt_next;
         neg       <= neg_next;
      end
   end

   // Shown value only changes on a finished conversion, never mid-way
   always_ff @(posedge Clock) begin
      if (Reset) begin
         hund      <= '0;
         tens      <= '0;
         units     <= '0;
         shown_neg <= 1'b0;
      end else if (show_load) begin
         hund      <= bcd[11:8];
         tens      <= bcd[7:4];
         units     <= bcd[3:0];
         shown_neg <= neg;
      end
   end

   // Digit slot timer: advances the scanned digit once per refresh period
   always_ff @(posedge Clock) begin
      if (Reset) begin
         refresh_cnt <= '0;
         digit_idx   <= '0;
      end else if (refresh_cnt == CNT_MAX) begin
         refresh_cnt <= '0;
         digit_idx   <= digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + CW'(1);
      end
   end

   // Segment pattern for the current slot, with leading-zero blanking
   always_comb begin
      seg_next   = SEG_BLANK;
      anode_next = ~(4'b0001 << digit_idx);
      if (Dval) begin
         case (digit_idx)
            2'd0: seg_next = seg_encode(units);
            2'd1: seg_next = ((hund == 4'd0) && (tens == 4'd0)) ? SEG_BLANK : seg_encode(tens);
            2'd2: seg_next = (hund == 4'd0) ? SEG_BLANK : seg_encode(hund);
            2'd3: seg_next = shown_neg ? SEG_MINUS : SEG_BLANK;
            default: seg_next = SEG_BLANK;
         endcase
      end
   end

   // Registered display drive, one cycle behind the digit index
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Seg   <= SEG_BLANK;
         Anode <= 4'b1111;
      end else begin
         Seg   <= seg_next;
         Anode <= anode_next;
      end
   end

endmodule

// File: tb/tb_dout_display.sv
// Scoreboard bench for dout_display: a signed and an unsigned instance share
// stimulus; converted values are queued and checked against the scanned display.
module tb_dout_display;

   localparam int REFRESH_DIV = 4;

   logic       clock;
   logic       reset;
   logic [7:0] dout;
   logic       dval;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] exp_vals[$];
   logic [7:0] model_cap;

   logic [6:0] segTable [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Free-running clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input int lane,
                              input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s lane%0d at %0t: got %h, expected %h",
                  name, lane, $time, actual, expected);
      end
   endtask

   // Expected four slot patterns {sign, hundreds, tens, units} for a byte
   function automatic logic [27:0] modelDisplay(input logic [7:0] v, input bit sgn);
      int val, m, h, t, u;
      logic [6:0] s_units, s_tens, s_hund, s_sign;
      val = int'(v);
      if (sgn && val >= 128) val = val - 256;
      m = (val < 0) ? -val : val;
      h = m / 100;
      t = (m / 10) % 10;
      u = m % 10;
      s_units = segTable[u];
      s_tens  = (h == 0 && t == 0) ? 7'h7F : segTable[t];
      s_hund  = (h == 0) ? 7'h7F : segTable[h];
      s_sign  = (val < 0) ? 7'h3F : 7'h7F;
      return {s_sign, s_hund, s_tens, s_units};
   endfunction

   for (genvar L = 0; L < 2; L++) begin : lane
      localparam bit SGN = (L == 0);
      logic [6:0]  seg;
      logic [3:0]  anode;
      logic        busy;
      logic [27:0] cur_exp   = 28'h0;
      int          rd        = 0;
      int          busy_len  = 0;
      int          slot;
      bit          busy_prev = 1'b0;
      bit          rst_prev  = 1'b1;
      bit          dval_prev = 1'b1;

      dout_display #(.REFRESH_DIV(REFRESH_DIV), .SIGNED(SGN ? 1 : 0)) dut (
         .Clock (clock),
         .Reset (reset),
         .Dout  (dout),
         .Dval  (dval),
         .Seg   (seg),
         .Anode (anode),
         .Busy  (busy)
      );

      // Monitor: checks every displayed slot, pops an expected value per conversion
      always @(negedge clock) begin
         if (rst_prev) begin
            checkOutput("reset_anode", L, 32'(anode), 32'hF);
            checkOutput("reset_seg", L, 32'(seg), 32'h7F);
            checkOutput("reset_busy", L, 32'(busy), 32'h0);
            rd       = exp_vals.size();
            cur_exp  = modelDisplay(8'h00, SGN);
            busy_len = 0;
         end else begin
            checkOutput("anode_onehot", L, 32'($countones(~anode)), 32'd1);
            slot = -1;
            for (int i = 0; i < 4; i++) begin
               if (anode == ~(4'b0001 << i)) slot = i;
            end
            if (slot >= 0) begin
               checkOutput($sformatf("seg_slot%0d", slot), L, 32'(seg),
                           dval_prev ? 32'(cur_exp[slot*7 +: 7]) : 32'h7F);
            end
            if (busy) busy_len++;
            if (busy_prev && !busy) begin
               checkOutput("busy_width", L, 32'(busy_len), 32'd10);
               checkOutput("conversion_expected", L, 32'(rd < exp_vals.size()), 32'd1);
               if (rd < exp_vals.size()) begin
                  cur_exp = modelDisplay(exp_vals[rd], SGN);
                  rd++;
               end
               busy_len = 0;
            end
         end
         busy_prev = busy;
         rst_prev  = reset;
         dval_prev = dval;
      end
   end

   task automatic holdCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic waitIdle();
      int budget;
      budget = 0;
      do begin
         @(posedge clock);
         #1;
         budget++;
      end while ((lane[0].busy || lane[1].busy) && budget < 100);
      if (budget >= 100) checkOutput("idle_timeout", -1, 32'd1, 32'd0);
   endtask

   // Drive a new word once idle; a capture is expected when valid and changed
   task automatic applyStimulus(input logic [7:0] value, input logic dv);
      waitIdle();
      dout = value;
      dval = dv;
      if (dv && value != model_cap) begin
         exp_vals.push_back(value);
         model_cap = value;
      end
   endtask

   // Directed sequences followed by randomized words and valid toggles
   initial begin
      reset     = 1'b1;
      dval      = 1'b1;
      dout      = 8'h00;
      model_cap = 8'h00;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      holdCycles(20);

      applyStimulus(8'd123, 1'b1);
      holdCycles(25);
      applyStimulus(8'h80, 1'b1);
      holdCycles(25);
      applyStimulus(8'hFF, 1'b1);
      holdCycles(25);
      applyStimulus(8'd5, 1'b1);
      holdCycles(25);

      applyStimulus(8'd10, 1'b1);
      holdCycles(3);
      dout = 8'd42;
      exp_vals.push_back(8'd42);
      model_cap = 8'd42;
      holdCycles(40);

      applyStimulus(8'd42, 1'b0);
      holdCycles(20);
      applyStimulus(8'd42, 1'b1);
      holdCycles(20);

      applyStimulus(8'd99, 1'b1);
      holdCycles(4);
      reset = 1'b1;
      dout  = 8'h00;
      holdCycles(2);
      reset = 1'b0;
      model_cap = 8'h00;
      holdCycles(20);

      for (int n = 0; n < 40; n++) begin
         applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
         holdCycles($urandom_range(0, 20));
      end

      applyStimulus(dout, 1'b1);
      waitIdle();
      holdCycles(20);
      checkOutput("all_conversions_seen", 0, 32'(lane[0].rd), 32'(exp_vals.size()));
      checkOutput("all_conversions_seen", 1, 32'(lane[1].rd), 32'(exp_vals.size()));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
